// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared loader state encoding, HALT word and width defaults
package mips_pkg;

    localparam int DEF_NB_INSTRUC = 32;
    localparam int DEF_NB_BYTE    = 8;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERROR,
        ST_CHECK
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in / program memory write bus out
interface program_loader_if #(
    parameter int NB_INSTRUC = 32,
    parameter int NB_BYTE    = 8,
    parameter int NB_PADDR   = 11
);

    logic [NB_BYTE-1:0]    i_rx_data;
    logic                  i_rx_valid;
    logic                  o_wr_en;
    logic [NB_PADDR-1:0]   o_wr_addr;
    logic [NB_INSTRUC-1:0] o_wr_data;

    modport master (
        input  i_rx_data,
        input  i_rx_valid,
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data
    );

    modport slave (
        output i_rx_data,
        output i_rx_valid,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data
    );

endinterface

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - big-endian byte-to-word shifter with word_valid pulse
module loader_word_assembler #(
    parameter int NB_INSTRUC = 32,
    parameter int NB_BYTE    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [NB_BYTE-1:0]    i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_word_valid,
    output logic [NB_INSTRUC-1:0] o_word
);

    localparam int BYTES  = NB_INSTRUC / NB_BYTE;
    localparam int NB_CNT = $clog2(BYTES);

    logic [NB_CNT-1:0]     cnt_q, cnt_d;
    logic [NB_INSTRUC-1:0] shift_q, shift_d;
    logic                  take;

    assign take = i_en && i_byte_valid;

    // Word including the byte currently on the input, so the owner can register it on the last strobe
    assign o_word       = {shift_q[NB_INSTRUC-NB_BYTE-1:0], i_byte};
    assign o_word_valid = take && (cnt_q == NB_CNT'(BYTES - 1));

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (i_clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (take) begin
            shift_d = o_word;
            cnt_d   = o_word_valid ? '0 : cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - fills program memory from a byte stream, holds CPU in reset; PROGRAM_LOADER_CHECKSUM_EN adds XOR check
module program_loader #(
    parameter int NB_INSTRUC        = mips_pkg::DEF_NB_INSTRUC,
    parameter int NB_BYTE           = mips_pkg::DEF_NB_BYTE,
    parameter int RAM_DEPTH_PROGRAM = 2048,
    parameter int NB_PADDR          = $clog2(RAM_DEPTH_PROGRAM),
    parameter logic [NB_INSTRUC-1:0] HALT_WORD = mips_pkg::HALT_WORD
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    program_loader_if.master    bus,
    output logic [NB_PADDR:0]   o_word_count,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic                o_cpu_rst
);

    import mips_pkg::*;

    state_e                state_q, state_d;
    logic [NB_PADDR-1:0]   index_q, index_d;
    logic [NB_PADDR:0]     count_q, count_d;
    logic                  wr_en_q, wr_en_d;
    logic [NB_PADDR-1:0]   wr_addr_q, wr_addr_d;
    logic [NB_INSTRUC-1:0] wr_data_q, wr_data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0]    xor_q, xor_d;
`endif

    logic                  start_ok;
    logic                  wr_halt;
    logic                  wr_last;
    logic                  wr_continue;
    logic                  asm_en;
    logic                  asm_word_valid;
    logic [NB_INSTRUC-1:0] asm_word;

    assign start_ok = i_start &&
                      (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
    assign wr_halt  = (wr_data_q == HALT_WORD);
    assign wr_last  = (wr_addr_q == NB_PADDR'(RAM_DEPTH_PROGRAM - 1));

    // A byte arriving during WRITE belongs to the next word only when loading continues
    assign wr_continue = (state_q == ST_WRITE) && !wr_halt && !wr_last;
    assign asm_en      = (state_q == ST_LOAD) || wr_continue;

    loader_word_assembler #(
        .NB_INSTRUC (NB_INSTRUC),
        .NB_BYTE    (NB_BYTE)
    ) u_asm (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (start_ok),
        .i_en         (asm_en),
        .i_byte       (bus.i_rx_data),
        .i_byte_valid (bus.i_rx_valid),
        .o_word_valid (asm_word_valid),
        .o_word       (asm_word)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
        if (asm_en && bus.i_rx_valid) begin
            xor_d = xor_q ^ bus.i_rx_data;
        end
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                    index_d = '0;
                    count_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (asm_word_valid) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = index_q;
                    wr_data_d = asm_word;
                    count_d   = count_q + (NB_PADDR + 1)'(1);
                end
            end
            ST_WRITE: begin
                if (wr_halt) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    // Checksum byte may already be on the line in the HALT write cycle
                    if (bus.i_rx_valid) begin
                        state_d = (bus.i_rx_data == xor_q) ? ST_DONE : ST_ERROR;
                    end else begin
                        state_d = ST_CHECK;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else if (wr_last) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_LOAD;
                    index_d = index_q + NB_PADDR'(1);
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.i_rx_valid) begin
                    state_d = (bus.i_rx_data == xor_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign o_word_count  = count_q;
    assign o_busy        = (state_q == ST_LOAD) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
    assign o_done        = (state_q == ST_DONE);
    assign o_error       = (state_q == ST_ERROR);
    assign o_cpu_rst     = (state_q != ST_DONE);

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart of the instruction fetch path: fills program memory from a byte stream (UART RX byte/strobe) before the CPU runs.
- Assembles bytes into big-endian 32-bit instruction words, writes them to consecutive program-memory addresses, and stops on a HALT word.
- Holds the CPU in reset until a load completes cleanly, then releases it.

Parameters:
- NB_INSTRUC, 32, instruction/word width.
- NB_BYTE, 8, width of the incoming byte stream.
- RAM_DEPTH_PROGRAM, 2048, program memory depth in words.
- NB_PADDR, 11, program memory word-address width; equals clog2(RAM_DEPTH_PROGRAM).
- HALT_WORD, 32'hFFFF_FFFF, terminating instruction word.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins a new load.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
- o_wr_en  out  1  program memory write enable, one cycle per word.
- o_wr_addr  out  NB_PADDR  program memory word address.
- o_wr_data  out  NB_INSTRUC  assembled instruction word.
- o_word_count  out  NB_PADDR+1  words written in the current or last load, HALT included.
- o_busy  out  1  high in LOAD, WRITE, CHECK.
- o_done  out  1  high in DONE.
- o_error  out  1  high in ERROR.
- o_cpu_rst  out  1  CPU reset; high in every state except DONE.

Behaviour:
- Reset (async, any state, mid-load included):
  - State goes to IDLE.
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_word_count=0, o_busy=0, o_done=0, o_error=0, o_cpu_rst=1.
  - Byte counter and shift register clear.
- State machine:
  - IDLE: i_start -> LOAD. i_rx_valid is ignored.
  - LOAD: each i_rx_valid shifts a byte in as {word[23:0], byte}, so the first byte lands in bits [31:24]. The 4th byte -> WRITE.
  - WRITE (exactly one cycle):
    - o_wr_en=1, o_wr_addr=word index, o_wr_data=assembled word; o_word_count increments.
    - If word==HALT_WORD -> DONE, or CHECK when CHECKSUM_EN is defined.
    - Else if the index just written is RAM_DEPTH_PROGRAM-1 -> ERROR (overflow, no HALT).
    - Else -> LOAD with index+1.
    - An i_rx_valid arriving in WRITE is captured as byte 0 of the next word, never dropped.
  - DONE: o_cpu_rst=0. i_start -> LOAD, which re-asserts o_cpu_rst the next cycle and zeroes index and count.
  - ERROR: o_cpu_rst stays 1; only i_start leaves (-> LOAD, cleared as above).
- i_start while in LOAD/WRITE/CHECK is ignored.
- o_wr_en and o_wr_data are registered; write latency is 1 cycle after the 4th byte strobe.
- o_wr_addr holds its last value when o_wr_en=0.
- Partial words (fewer than 4 bytes) are never written.

Optional Feature:
- Macro PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers every byte from LOAD entry up to and including the HALT word.
  - After the HALT write, state CHECK waits for one more byte.
  - Byte equal to the XOR -> DONE; otherwise -> ERROR.
  - The checksum byte is not written to memory.
- Not defined: no CHECK state; HALT write goes directly to DONE.

Decomposition:
- Shared package mips_pkg holds:
  - the state enumeration (IDLE, LOAD, WRITE, DONE, ERROR, CHECK);
  - the HALT_WORD constant;
  - the NB_INSTRUC and NB_BYTE defaults.
- One sub-module, loader_word_assembler: byte counter plus shift register with a word_valid pulse.
- The FSM and address counter stay in program_loader.

Test Plan:
- Reset mid-load: start, send 2 bytes, pulse i_rst -> all outputs at reset values. Start, then 00 00 00 20 FF FF FF FF -> writes addr0=0x0000_0020, addr1=0xFFFF_FFFF; done=1, count=2, cpu_rst=0.
- Byte order: send 12 34 56 78 -> o_wr_data=0x1234_5678 with o_wr_en exactly 1 cycle after the 4th strobe.
- Back-to-back: a byte strobe in the WRITE cycle -> no loss; next word is assembled correctly at addr+1.
- Overflow: RAM_DEPTH_PROGRAM=4, send 4 non-HALT words -> 4 writes (addr 0..3), then error=1, cpu_rst=1. i_start -> busy=1, count=0.
- Reload: after DONE, i_start with 1 HALT word -> cpu_rst high for at least 1 cycle, single write at addr 0, done=1, count=1.
- Checksum (macro defined): words 01 02 03 04 + FF FF FF FF; checksum byte 0x04 -> done. Byte 0x05 -> error.
